// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler_if
// Brief    : Writeback pair, register-file write port and decode read-port
//            bundle shared by the writeback scheduler and its neighbours.
// Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_scheduler_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] dstE;
    logic [DATA_W-1:0] valE;
    logic [ADDR_W-1:0] dstM;
    logic [DATA_W-1:0] valM;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic [DATA_W-1:0] rf_rdataA;
    logic [DATA_W-1:0] rf_rdataB;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [2:0]        pending;

    modport slave (
        input  wb_valid, dstE, valE, dstM, valM, srcA, srcB, rf_rdataA, rf_rdataB,
        output wb_ready, rf_we, rf_waddr, rf_wdata, valA, valB, pending
    );

    modport master (
        output wb_valid, dstE, valE, dstM, valM, srcA, srcB, rf_rdataA, rf_rdataB,
        input  wb_ready, rf_we, rf_waddr, rf_wdata, valA, valB, pending
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Brief    : Queues E/M writeback results into a small FIFO, drains one
//            register-file write per cycle and forwards pending data to the
//            decode read ports. Optional macro: WB_COALESCE_EN.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_scheduler #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RNONE      = 15
) (
    input wire clk,
    input wire rst_n,
    regfile_wb_scheduler_if.slave bus
);

    localparam int                c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] c_RNONE     = ADDR_W'(RNONE);
    localparam logic [c_CNT_W-1:0] c_READY_MAX = c_CNT_W'(FIFO_DEPTH - 2);

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [ADDR_W-1:0]  r_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  r_data [FIFO_DEPTH];

    logic               w_ready;
    logic               w_accept;
    logic               w_push_e;
    logic               w_push_m;
    logic               w_pop;
    logic               w_we;
    logic [c_PTR_W-1:0] w_tail1;
    logic [c_PTR_W-1:0] w_tail2;
    logic [c_PTR_W-1:0] w_m_slot;
    logic [c_PTR_W-1:0] w_tail_nxt;
    logic [c_PTR_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_val_a;
    logic [DATA_W-1:0]  w_val_b;

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // A pair can push up to two entries, so accept only with two free slots.
    assign w_ready  = rst_n && (r_count <= c_READY_MAX);
    assign w_accept = bus.wb_valid && w_ready;

`ifdef WB_COALESCE_EN
    assign w_push_e = w_accept && (bus.dstE != c_RNONE) && (bus.dstE != bus.dstM);
`else
    assign w_push_e = w_accept && (bus.dstE != c_RNONE);
`endif
    assign w_push_m = w_accept && (bus.dstM != c_RNONE);
    assign w_pop    = (r_count != '0);

    assign w_tail1    = f_inc(r_tail);
    assign w_tail2    = f_inc(w_tail1);
    assign w_m_slot   = w_push_e ? w_tail1 : r_tail;
    assign w_tail_nxt = (w_push_e && w_push_m) ? w_tail2 :
                        (w_push_e || w_push_m) ? w_tail1 : r_tail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= w_tail_nxt;
            if (w_pop) begin
                r_head <= f_inc(r_head);
            end
            r_count <= r_count + c_CNT_W'(w_push_e) + c_CNT_W'(w_push_m)
                               - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_e) begin
            r_addr[r_tail] <= bus.dstE;
            r_data[r_tail] <= bus.valE;
        end
        if (w_push_m) begin
            r_addr[w_m_slot] <= bus.dstM;
            r_data[w_m_slot] <= bus.valM;
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_val_a = bus.rf_rdataA;
        w_val_b = bus.rf_rdataB;
        w_idx   = r_head;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (c_CNT_W'(i) < r_count) begin
                if ((bus.srcA != c_RNONE) && (r_addr[w_idx] == bus.srcA)) begin
                    w_val_a = r_data[w_idx];
                end
                if ((bus.srcB != c_RNONE) && (r_addr[w_idx] == bus.srcB)) begin
                    w_val_b = r_data[w_idx];
                end
            end
            w_idx = f_inc(w_idx);
        end
    end

    assign w_we         = rst_n && (r_count != '0);
    assign bus.wb_ready = w_ready;
    assign bus.rf_we    = w_we;
    assign bus.rf_waddr = w_we ? r_addr[r_head] : '0;
    assign bus.rf_wdata = w_we ? r_data[r_head] : '0;
    assign bus.valA     = w_val_a;
    assign bus.valB     = w_val_b;
    assign bus.pending  = 3'(r_count);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Brief    : Directed scoreboard bench for regfile_wb_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_scheduler;

    localparam int DEPTH = 4;
    localparam logic [3:0] RN = 4'd15;

    typedef struct packed {
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    bit   acc;
    int   n_w2;
    int   k;
    wr_t  sb[$];
    logic [63:0] rf_bench [16];

    regfile_wb_scheduler_if #(.DATA_W(64), .ADDR_W(4)) bus ();

    regfile_wb_scheduler #(
        .DATA_W(64), .ADDR_W(4), .FIFO_DEPTH(DEPTH), .RNONE(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_fwd(input logic [3:0] src, input logic [63:0] raw);
        logic [63:0] v;
        v = raw;
        if (src != RN) begin
            foreach (sb[i]) begin
                if (sb[i].addr == src) v = sb[i].data;
            end
        end
        return v;
    endfunction

    task automatic drive(input logic v, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        bus.wb_valid = v;
        bus.dstE     = de;
        bus.valE     = ve;
        bus.dstM     = dm;
        bus.valM     = vm;
    endtask

    // One cycle: compare outputs against the model, then apply accepted pushes.
    task automatic tick();
        bit  mready;
        wr_t e;
        #1;
        mready = rst_n && (sb.size() <= DEPTH - 2);
        chk("wb_ready", {63'd0, bus.wb_ready}, {63'd0, mready});
        chk("pending", {61'd0, bus.pending}, 64'(sb.size()));
        chk("valA", bus.valA, model_fwd(bus.srcA, bus.rf_rdataA));
        chk("valB", bus.valB, model_fwd(bus.srcB, bus.rf_rdataB));
        acc = 1'b0;
        if (!rst_n) begin
            chk("rst_rf_we", {63'd0, bus.rf_we}, 64'd0);
            chk("rst_waddr", {60'd0, bus.rf_waddr}, 64'd0);
            chk("rst_wdata", bus.rf_wdata, 64'd0);
            sb.delete();
        end else begin
            chk("rf_we", {63'd0, bus.rf_we}, {63'd0, (sb.size() != 0)});
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rf_waddr", {60'd0, bus.rf_waddr}, {60'd0, e.addr});
                chk("rf_wdata", bus.rf_wdata, e.data);
            end
            if (bus.rf_we === 1'b1) begin
                rf_bench[bus.rf_waddr] = bus.rf_wdata;
                if (bus.rf_waddr == 4'd2) n_w2++;
            end
            acc = bus.wb_valid && mready;
            if (acc) begin
`ifdef WB_COALESCE_EN
                if (bus.dstE != RN && bus.dstE != bus.dstM) sb.push_back({bus.dstE, bus.valE});
`else
                if (bus.dstE != RN) sb.push_back({bus.dstE, bus.valE});
`endif
                if (bus.dstM != RN) sb.push_back({bus.dstM, bus.valM});
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        drive(1'b0, RN, 64'd0, RN, 64'd0);
        for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_w2  = 0;
        foreach (rf_bench[i]) rf_bench[i] = 64'd0;
        rst_n = 1'b0;
        drive(1'b0, RN, 64'd0, RN, 64'd0);
        bus.srcA      = 4'd3;
        bus.srcB      = 4'd5;
        bus.rf_rdataA = 64'hAAAA_0000_0000_00AA;
        bus.rf_rdataB = 64'hBBBB_0000_0000_00BB;

        // Reset held two cycles, then released
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic pair, E then M
        drive(1'b1, 4'd3, 64'h11, 4'd5, 64'h22);
        tick();
        drain();

        // Both RNONE: nothing queued
        drive(1'b1, RN, 64'h33, RN, 64'h44);
        tick();
        drain();

        // Only M valid; RNONE read index must pass raw data
        bus.srcA = RN;
        bus.srcB = 4'd4;
        drive(1'b1, RN, 64'h55, 4'd4, 64'h44);
        tick();
        drain();

        // Back-to-back pairs with repeated destination, requester holds until accepted
        bus.srcA = 4'd7;
        bus.srcB = 4'd9;
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            drive(1'b1, 4'd7, 64'h100 + 64'(k), 4'(k + 8), 64'h200 + 64'(k));
            tick();
            if (acc) k++;
        end
        chk("b2b_accepted", 64'(k), 64'd4);
        drain();

        // Same destination in both slots; M must win
        bus.srcA = 4'd2;
        bus.srcB = 4'd3;
        n_w2 = 0;
        drive(1'b1, 4'd2, 64'h1, 4'd2, 64'h2);
        tick();
        drive(1'b0, RN, 64'd0, RN, 64'd0);
        tick();
        drain();
        chk("same_dst_final", rf_bench[2], 64'h2);
`ifdef WB_COALESCE_EN
        chk("same_dst_writes", 64'(n_w2), 64'd1);
`else
        chk("same_dst_writes", 64'(n_w2), 64'd2);
`endif

        // Reset with three entries pending discards them
        bus.srcA = 4'd10;
        bus.srcB = 4'd12;
        drive(1'b1, 4'd10, 64'hA0, 4'd11, 64'hB0);
        tick();
        drive(1'b1, 4'd12, 64'hC0, 4'd13, 64'hD0);
        tick();
        chk("pre_reset_pending", {61'd0, bus.pending}, 64'd3);
        drive(1'b0, RN, 64'd0, RN, 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
